drum_lod_pipe: RTL and testbench

- Parametrised, pipelined leading-one detector and DRUM truncation stage. It is the front end of each DRUM multiplier operand path.
- For each operand it produces:
  - a one-hot leading-one vector,
  - the binary leading-one position,
  - a zero flag,
  - the K-bit DRUM-truncated mantissa (LSB forced to 1),
  - the left-shift amount the product path needs.
- Two register stages with valid/ready handshake and full throughput, so it drops into the pipelined multiplier datapath.

---
 rtl/drum_pkg.sv | 24 ++
 rtl/lod_core.sv | 39 +++
 rtl/drum_lod_pipe.sv | 111 +++++++++++
 tb/tb_drum_lod_pipe.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/drum_pkg.sv
// Shared constants and types for the DRUM multiplier operand front end.
package drum_pkg;

  localparam int W_DEF = 16;
  localparam int K_DEF = 6;

  function automatic int clog2_w(input int w);
    int r;
    r = 0;
    while ((1 << r) < w) begin
      r = r + 1;
    end
    return r;
  endfunction

  localparam int PW_DEF = clog2_w(W_DEF);

  typedef struct packed {
    logic [W_DEF-1:0]  onehot;
    logic [PW_DEF-1:0] pos;
    logic              zero;
  } lod_res_t;

endpackage

// File: rtl/lod_core.sv
// Combinational leading-one detector: one-hot of the MSB set, its index, and a zero flag.
module lod_core
  import drum_pkg::*;
#(
  parameter int W  = W_DEF,
  parameter int PW = clog2_w(W)
) (
  input  logic [W-1:0]  din,
  output logic [W-1:0]  onehot,
  output logic [PW-1:0] pos,
  output logic          zero
);

  logic [W-1:0] fill_s;

  // Log-depth prefix OR toward the LSB: fill_s[i] is set when any bit at or above i is set.
  always_comb begin
    fill_s = din;
    for (int s = 1; s < W; s = s * 2) begin
      fill_s = fill_s | (fill_s >> s);
    end
  end

  assign onehot = din & ~(fill_s >> 1);
  assign zero   = ~|din;

  // Binary encode of the one-hot vector.
  always_comb begin
    pos = '0;
    for (int i = 0; i < W; i++) begin
      if (onehot[i]) begin
        pos = pos | PW'(i);
      end else begin
        pos = pos;
      end
    end
  end

endmodule

// File: rtl/drum_lod_pipe.sv
// Two-stage leading-one detect and DRUM truncation with valid/ready flow control.
module drum_lod_pipe
  import drum_pkg::*;
#(
  parameter int W  = W_DEF,
  parameter int K  = K_DEF,
  parameter int PW = clog2_w(W)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [W-1:0]  din,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [W-1:0]  onehot,
  output logic [PW-1:0] pos,
  output logic          zero,
  output logic [K-1:0]  trunc,
  output logic [PW-1:0] shift
);

  logic          s2_ready_s;
  logic          s1_load_s;
  logic          s2_load_s;
  logic          s1_valid_r;
  logic          s2_valid_r;
  logic [W-1:0]  s1_din_r;
  logic [W-1:0]  s1_onehot_r;
  logic [PW-1:0] s1_pos_r;
  logic          s1_zero_r;
  logic [W-1:0]  lod_onehot_s;
  logic [PW-1:0] lod_pos_s;
  logic          lod_zero_s;
  logic [K-1:0]  trunc_s;
  logic [PW-1:0] shift_s;

  lod_core #(.W(W), .PW(PW)) u_lod (
    .din    (din),
    .onehot (lod_onehot_s),
    .pos    (lod_pos_s),
    .zero   (lod_zero_s)
  );

  assign s2_ready_s = !s2_valid_r || out_ready;
  assign in_ready   = !s1_valid_r || s2_ready_s;
  assign s1_load_s  = in_valid && in_ready;
  assign s2_load_s  = s1_valid_r && s2_ready_s;
  assign out_valid  = s2_valid_r;

  // DRUM truncation: keep K-1 bits below the leading one and force the LSB, unless already exact.
  always_comb begin
    trunc_s = '0;
    shift_s = '0;
    if (s1_zero_r) begin
      trunc_s = '0;
      shift_s = '0;
    end else if ({1'b0, s1_pos_r} < (PW+1)'(K)) begin
      trunc_s = s1_din_r[K-1:0];
      shift_s = '0;
    end else begin
      shift_s = s1_pos_r - PW'(K-1);
      trunc_s = K'(s1_din_r >> shift_s) | {{(K-1){1'b0}}, 1'b1};
    end
  end

  // Stage 1: capture operand and detector result; data only moves on an accepted transfer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_r  <= 1'b0;
      s1_din_r    <= '0;
      s1_onehot_r <= '0;
      s1_pos_r    <= '0;
      s1_zero_r   <= 1'b0;
    end else begin
      if (in_ready) begin
        s1_valid_r <= in_valid;
      end
      if (s1_load_s) begin
        s1_din_r    <= din;
        s1_onehot_r <= lod_onehot_s;
        s1_pos_r    <= lod_pos_s;
        s1_zero_r   <= lod_zero_s;
      end
    end
  end

  // Stage 2: registered outputs, held stable while downstream stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid_r <= 1'b0;
      onehot     <= '0;
      pos        <= '0;
      zero       <= 1'b0;
      trunc      <= '0;
      shift      <= '0;
    end else begin
      if (s2_ready_s) begin
        s2_valid_r <= s1_valid_r;
      end
      if (s2_load_s) begin
        onehot <= s1_onehot_r;
        pos    <= s1_pos_r;
        zero   <= s1_zero_r;
        trunc  <= trunc_s;
        shift  <= shift_s;
      end
    end
  end

endmodule

// File: tb/tb_drum_lod_pipe.sv
// Scoreboard bench for drum_lod_pipe with W = 16, K = 6.
module tb_drum_lod_pipe;

  localparam int W  = 16;
  localparam int K  = 6;
  localparam int PW = 4;

  typedef struct packed {
    logic [15:0] onehot;
    logic [3:0]  pos;
    logic        zero;
    logic [5:0]  trunc;
    logic [3:0]  shift;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          in_valid = 1'b0;
  logic          out_ready = 1'b0;
  logic [W-1:0]  din = '0;
  logic          in_ready;
  logic          out_valid;
  logic [W-1:0]  onehot;
  logic [PW-1:0] pos;
  logic          zero;
  logic [K-1:0]  trunc;
  logic [PW-1:0] shift;

  exp_t exp_q[$];
  exp_t cur_exp = '0;
  logic cur_dir = 1'b0;
  exp_t held = '0;
  logic held_v = 1'b0;
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 clk = ~clk;

  drum_lod_pipe #(.W(W), .K(K)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .din       (din),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .onehot    (onehot),
    .pos       (pos),
    .zero      (zero),
    .trunc     (trunc),
    .shift     (shift)
  );

  function automatic exp_t mk(input logic [15:0] oh, input logic [3:0] p, input logic z,
                              input logic [5:0] t, input logic [3:0] s);
    exp_t e;
    e.onehot = oh; e.pos = p; e.zero = z; e.trunc = t; e.shift = s;
    return e;
  endfunction

  // Reference: leading one is floor(log2 d); truncation is the top K bits from it with LSB forced.
  function automatic exp_t model(input logic [15:0] d);
    exp_t e;
    int   p;
    int   v;
    e = '0;
    v = int'(d);
    if (v == 0) begin
      e.zero = 1'b1;
    end else begin
      p = 0;
      while ((v >> (p + 1)) != 0) p++;
      e.pos    = 4'(p);
      e.onehot = 16'(1 << p);
      if (p < K) begin
        e.trunc = 6'(v % (1 << K));
      end else begin
        e.shift = 4'(p - K + 1);
        e.trunc = 6'((v / (1 << (p - K + 1))) % (1 << K)) | 6'd1;
      end
    end
    return e;
  endfunction

  function automatic exp_t pack_out();
    exp_t e;
    e.onehot = onehot; e.pos = pos; e.zero = zero; e.trunc = trunc; e.shift = shift;
    return e;
  endfunction

  task automatic chk(input string name, input int act, input int req);
    n_checks++;
    if (act != req) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  task automatic chk_out(input string name, input exp_t act, input exp_t req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s: got onehot=%h pos=%0d zero=%0b trunc=%h shift=%0d, expected onehot=%h pos=%0d zero=%0b trunc=%h shift=%0d",
               name, act.onehot, act.pos, act.zero, act.trunc, act.shift,
               req.onehot, req.pos, req.zero, req.trunc, req.shift);
    end
  endtask

  // Monitor: checks output transfers and stall stability, records expectations on acceptance.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        exp_q.delete();
        held_v = 1'b0;
      end else begin
        if (held_v) chk_out("hold_stable", pack_out(), held);
        held_v = out_valid && !out_ready;
        held   = pack_out();
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL unexpected_output: got onehot=%h with empty scoreboard", onehot);
          end else begin
            chk_out("data", pack_out(), exp_q.pop_front());
          end
        end
        if (in_valid && in_ready) exp_q.push_back(cur_dir ? cur_exp : model(din));
      end
    end
  end

  // Holds the presented operand until the DUT accepts it; called just after a rising edge.
  task automatic wait_accept(input string name);
    bit ok;
    ok = 1'b0;
    for (int t = 0; t < 40; t++) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
    if (!ok) chk(name, 0, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic send(input logic [15:0] d, input logic dir, input exp_t e);
    in_valid = 1'b1;
    din      = d;
    cur_dir  = dir;
    cur_exp  = e;
    wait_accept("accept_timeout");
  endtask

  task automatic drain();
    out_ready = 1'b1;
    for (int t = 0; t < 50; t++) begin
      if (exp_q.size() == 0) break;
      @(posedge clk); #1;
    end
    chk("drain_empty", exp_q.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    bit acc;
    #2 rst_n = 1'b0;
    @(posedge clk); #1;
    chk("rst_out_valid", int'(out_valid), 0);
    chk_out("rst_outputs", pack_out(), '0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rst_in_ready", int'(in_ready), 1);

    out_ready = 1'b1;
    send(16'h0000, 1'b1, mk(16'h0000, 4'd0,  1'b1, 6'h00, 4'd0));
    send(16'h8000, 1'b1, mk(16'h8000, 4'd15, 1'b0, 6'h21, 4'd10));
    send(16'h1234, 1'b1, mk(16'h1000, 4'd12, 1'b0, 6'h25, 4'd7));
    send(16'h0025, 1'b1, mk(16'h0020, 4'd5,  1'b0, 6'h25, 4'd0));
    drain();

    out_ready = 1'b0;
    send(16'h0001, 1'b1, mk(16'h0001, 4'd0, 1'b0, 6'h01, 4'd0));
    send(16'h00FF, 1'b1, mk(16'h0080, 4'd7, 1'b0, 6'h3F, 4'd2));
    in_valid = 1'b1;
    din      = 16'hFFFF;
    cur_dir  = 1'b1;
    cur_exp  = mk(16'h8000, 4'd15, 1'b0, 6'h3F, 4'd10);
    for (int c = 0; c < 5; c++) begin
      chk("bp_in_ready", int'(in_ready), 0);
      chk("bp_out_valid", int'(out_valid), 1);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    wait_accept("bp_third_timeout");
    drain();

    in_valid = 1'b0;
    for (int c = 0; c < 800; c++) begin
      @(negedge clk);
      acc = in_valid && in_ready;
      @(posedge clk); #1;
      if (acc || !in_valid) begin
        in_valid = ($urandom_range(0, 3) != 0);
        din      = 16'($urandom) >> $urandom_range(0, 16);
        cur_dir  = 1'b0;
      end
      out_ready = ($urandom_range(0, 3) != 0);
    end
    in_valid = 1'b0;
    drain();

    out_ready = 1'b0;
    send(16'h0100, 1'b0, '0);
    send(16'h0200, 1'b0, '0);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", int'(out_valid), 0);
    chk_out("midrst_outputs", pack_out(), '0);
    @(negedge clk);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_in_ready", int'(in_ready), 1);
    chk("post_rst_out_valid", int'(out_valid), 0);

    out_ready = 1'b1;
    in_valid  = 1'b1;
    din       = 16'h1234;
    cur_dir   = 1'b1;
    cur_exp   = mk(16'h1000, 4'd12, 1'b0, 6'h25, 4'd7);
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("latency_cycle1", int'(out_valid), 0);
    @(posedge clk); #1;
    chk("latency_cycle2", int'(out_valid), 1);
    @(posedge clk); #1;
    drain();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
